// File: rtl/pwm_clk_gen_pkg.sv
// Shared definitions for the multi-channel PWM / clock generator.
package pwm_pkg;

  localparam int CNT_W_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Config address width: channel duties at 0..n_ch-1, period at n_ch.
  function automatic int addr_w(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  function automatic int addr_period(input int n_ch);
    return n_ch;
  endfunction

endpackage

// File: rtl/pwm_clk_gen_if.sv
// Configuration write port of pwm_clk_gen: write strobe, address, data and status.
interface pwm_cfg_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = pwm_pkg::CNT_W_DEF
);
  import pwm_pkg::*;

  localparam int AW = addr_w(N_CH);

  logic            cfg_wr;
  logic [AW-1:0]   cfg_addr;
  logic [CNT_W:0]  cfg_data;
  logic            cfg_err;
  logic            upd_pending;

  modport master (
    output cfg_wr, cfg_addr, cfg_data,
    input  cfg_err, upd_pending
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data,
    output cfg_err, upd_pending
  );

endinterface

// File: rtl/pwm_clk_gen_chan.sv
// One PWM channel: double-buffered duty, compare against the shared counter,
// optional inversion and a registered output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit INV      = 1'b0,
  parameter int RST_DUTY = 307
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             shd_we,
  input  logic [CNT_W:0]   shd_data,
  input  logic             apply,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  logic [CNT_W:0] duty_shd_q;
  logic [CNT_W:0] duty_act_q;
  logic           cmp;

  // Duty is one bit wider than the counter so 100% is reachable at max period.
  assign cmp = ({1'b0, cnt} < duty_act_q) ^ INV;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      duty_shd_q <= (CNT_W + 1)'(RST_DUTY);
      duty_act_q <= (CNT_W + 1)'(RST_DUTY);
      pwm        <= 1'b0;
    end else begin
      // Transfer reads the shadow before a same-edge write updates it.
      if (apply) duty_act_q <= duty_shd_q;
      if (shd_we) duty_shd_q <= shd_data;
      pwm <= run ? cmp : 1'b0;
    end
  end

endmodule

// File: rtl/pwm_clk_gen.sv
// Multi-channel PWM / clock generator: shared period counter, run/stop FSM,
// double-buffered period and duty applied only at period boundaries.
//
// state | meaning
// IDLE  | stopped: cnt held at 0, outputs low, shadow writes accepted
// RUN   | counting 0..active_period, outputs follow per-channel compare
module pwm_clk_gen
  import pwm_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter int              CNT_W      = CNT_W_DEF,
  parameter logic [N_CH-1:0] INV_MASK   = '0,
  parameter int              RST_PERIOD = 1023,
  parameter int              RST_DUTY   = 307
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            enable,
  pwm_cfg_if.slave        cfg,
  output logic            period_tick,
  output logic [N_CH-1:0] pwm_o
);

  localparam int            AW     = addr_w(N_CH);
  localparam logic [AW-1:0] ADDR_P = AW'(addr_period(N_CH));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_act_q, per_shd_q;
  logic             wrap, entry, apply, run;
  logic             wr_ok, wr_bad, per_we;
  logic [N_CH-1:0]  duty_we;
  logic             pend_q, err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    entry   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = RUN;
          entry   = 1'b1;
        end
      end
      RUN: begin
        wrap  = (cnt_q == per_act_q);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign apply       = wrap | entry;
  // Outputs are forced low on the edge that leaves RUN and on the entry edge.
  assign run         = (state_q == RUN) && enable;
  assign period_tick = wrap;

  assign wr_ok  = cfg.cfg_wr && (cfg.cfg_addr <= ADDR_P);
  assign wr_bad = cfg.cfg_wr && (cfg.cfg_addr >  ADDR_P);
  assign per_we = wr_ok && (cfg.cfg_addr == ADDR_P);

  always_comb begin
    duty_we = '0;
    for (int i = 0; i < N_CH; i++) begin
      duty_we[i] = wr_ok && (cfg.cfg_addr == AW'(i));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      per_act_q <= CNT_W'(RST_PERIOD);
      per_shd_q <= CNT_W'(RST_PERIOD);
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (apply) per_act_q <= per_shd_q;
      if (per_we) per_shd_q <= cfg.cfg_data[CNT_W-1:0];
      // A write landing on the apply edge stays pending for the next boundary.
      pend_q <= (pend_q & ~apply) | wr_ok;
      err_q  <= wr_bad;
    end
  end

  assign cfg.upd_pending = pend_q;
  assign cfg.cfg_err     = err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_chan #(
      .CNT_W    (CNT_W),
      .INV      (INV_MASK[i]),
      .RST_DUTY (RST_DUTY)
    ) u_chan (
      .CLK      (CLK),
      .RST      (RST),
      .shd_we   (duty_we[i]),
      .shd_data (cfg.cfg_data),
      .apply    (apply),
      .run      (run),
      .cnt      (cnt_q),
      .pwm      (pwm_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_clk_gen.sv
// Directed bench for pwm_clk_gen: two instances (plain and ch0 inverted) on the same stimulus.
module tb_pwm_clk_gen;

  localparam int N_CH  = 4;
  localparam int CNT_W = 10;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             enable = 1'b0;
  logic             cfg_wr = 1'b0;
  logic [2:0]       cfg_addr = '0;
  logic [CNT_W:0]   cfg_data = '0;
  logic             tick0, tick1;
  logic [N_CH-1:0]  pwm0, pwm1;

  int n_chk = 0;
  int n_err = 0;
  int m_len;
  int m_hi[N_CH];
  int m_hi_inv;

  pwm_cfg_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg0 ();
  pwm_cfg_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg1 ();

  assign cfg0.cfg_wr   = cfg_wr;
  assign cfg0.cfg_addr = cfg_addr;
  assign cfg0.cfg_data = cfg_data;
  assign cfg1.cfg_wr   = cfg_wr;
  assign cfg1.cfg_addr = cfg_addr;
  assign cfg1.cfg_data = cfg_data;

  always #5 CLK = ~CLK;

  pwm_clk_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .INV_MASK(4'b0000), .RST_PERIOD(1023), .RST_DUTY(307)
  ) dut0 (
    .CLK(CLK), .RST(RST), .enable(enable), .cfg(cfg0), .period_tick(tick0), .pwm_o(pwm0)
  );

  pwm_clk_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .INV_MASK(4'b0001), .RST_PERIOD(1023), .RST_DUTY(307)
  ) dut1 (
    .CLK(CLK), .RST(RST), .enable(enable), .cfg(cfg1), .period_tick(tick1), .pwm_o(pwm1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_wr   = 1'b1;
    cfg_addr = addr[2:0];
    cfg_data = data[CNT_W:0];
    tick();
    cfg_wr   = 1'b0;
  endtask

  // Wait for a wrap cycle, then step into cnt=0 of the next period.
  task automatic sync();
    int n;
    n = 0;
    while (!tick0 && n < 3000) begin
      tick();
      n++;
    end
    check("sync_tick", int'(tick0), 1);
    tick();
  endtask

  // Starting at a cnt=0 sample: count one period's length and high cycles
  // (pwm lags cnt by one, so the window is shifted by one sample).
  task automatic measure();
    logic last;
    m_len    = 0;
    m_hi_inv = 0;
    for (int i = 0; i < N_CH; i++) m_hi[i] = 0;
    last = tick0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      m_len++;
      for (int i = 0; i < N_CH; i++) if (pwm0[i]) m_hi[i]++;
      if (pwm1[0]) m_hi_inv++;
      if (last) break;
      last = tick0;
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_pwm", int'(pwm0), 0);
    RST = 1'b0;
    tick();
    check("idle_pwm", int'(pwm0), 0);
    check("idle_pwm_inv", int'(pwm1), 0);
    check("idle_tick", int'(tick0), 0);
    check("idle_err", int'(cfg0.cfg_err), 0);
    check("idle_pend", int'(cfg0.upd_pending), 0);

    // Reset defaults: 1024-cycle period, 307 high
    enable = 1'b1;
    sync();
    measure();
    check("def_len", m_len, 1024);
    check("def_hi0", m_hi[0], 307);
    check("def_hi3", m_hi[3], 307);
    check("def_inv_hi0", m_hi_inv, 717);

    // Mid-period reprogramming
    repeat (3) tick();
    cfg_write(4, 9);
    check("mid_pend", int'(cfg0.upd_pending), 1);
    cfg_write(0, 3);
    cfg_write(1, 0);
    cfg_write(2, 10);
    cfg_write(3, 5);
    check("mid_pend2", int'(cfg0.upd_pending), 1);
    sync();
    check("applied_pend", int'(cfg0.upd_pending), 0);
    measure();
    check("p9_len", m_len, 10);
    check("p9_hi0", m_hi[0], 3);
    check("p9_hi1", m_hi[1], 0);
    check("p9_hi2", m_hi[2], 10);
    check("p9_hi3", m_hi[3], 5);
    check("p9_inv_hi0", m_hi_inv, 7);

    // Write in the wrap cycle lands one period later
    repeat (9) tick();
    check("wrap_cycle_tick", int'(tick0), 1);
    cfg_write(0, 6);
    check("wrap_pend", int'(cfg0.upd_pending), 1);
    measure();
    check("wrap_old_len", m_len, 10);
    check("wrap_old_hi0", m_hi[0], 3);
    check("wrap_pend_clr", int'(cfg0.upd_pending), 0);
    measure();
    check("wrap_new_hi0", m_hi[0], 6);

    // Drop enable at cnt=4, rewrite period in IDLE, re-enable
    repeat (4) tick();
    check("pre_drop_pwm", int'(pwm0), 4'b1101);
    enable = 1'b0;
    tick();
    check("drop_pwm", int'(pwm0), 0);
    check("drop_pwm_inv", int'(pwm1), 0);
    check("drop_tick", int'(tick0), 0);
    repeat (3) tick();
    check("idle_inv_ch0", int'(pwm1), 0);
    cfg_write(4, 3);
    check("idle_wr_pend", int'(cfg0.upd_pending), 1);
    enable = 1'b1;
    tick();
    check("entry_pend", int'(cfg0.upd_pending), 0);
    measure();
    check("p3_len", m_len, 4);
    check("p3_hi0", m_hi[0], 4);
    check("p3_hi1", m_hi[1], 0);
    check("p3_hi2", m_hi[2], 4);
    check("p3_hi3", m_hi[3], 4);
    check("p3_inv_hi0", m_hi_inv, 0);

    // Out-of-range addresses
    cfg_write(5, 1);
    check("err5_pulse", int'(cfg0.cfg_err), 1);
    check("err5_pend", int'(cfg0.upd_pending), 0);
    tick();
    check("err5_clear", int'(cfg0.cfg_err), 0);
    cfg_write(7, 0);
    check("err7_pulse", int'(cfg0.cfg_err), 1);
    sync();
    measure();
    check("err_len", m_len, 4);
    check("err_hi0", m_hi[0], 4);

    // Period 0: every cycle wraps
    cfg_write(4, 0);
    cfg_write(0, 0);
    cfg_write(1, 1);
    sync();
    check("p0_tick", int'(tick0), 1);
    tick();
    check("p0_tick2", int'(tick0), 1);
    check("p0_pwm", int'(pwm0), 4'b1110);
    check("p0_pwm_inv", int'(pwm1), 4'b1111);

    // Asynchronous reset mid-run
    RST = 1'b1;
    #1;
    check("arst_pwm", int'(pwm0), 0);
    check("arst_pwm_inv", int'(pwm1), 0);
    check("arst_tick", int'(tick0), 0);
    tick();
    RST = 1'b0;
    tick();
    sync();
    measure();
    check("arst_len", m_len, 1024);
    check("arst_hi0", m_hi[0], 307);
    check("arst_hi1", m_hi[1], 307);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
